// File: rtl/colocar_bombas.sv
// rtl/colocar_bombas.sv - minesweeper board generator: clears an 8x8 board and scatters bombs via an LFSR
module colocar_bombas #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            num_bombs,
  input  logic [2:0]            safe_row,
  input  logic [2:0]            safe_col,
  output logic [7:0][7:0][3:0]  matrizBombastic,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_PLACE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_lfsr;
  logic [63:0] r_mask;
  logic [5:0]  r_count;
  logic [5:0]  r_nb;
  logic [2:0]  r_sr;
  logic [2:0]  r_sc;

  // Cells are only ever 0 or 15, so the board is kept as a one-bit-per-cell mask.
  logic [5:0]  w_idx;
  logic        w_hit_safe;
  logic        w_accept;
  logic [5:0]  w_count_inc;
  logic        w_take_start;

  assign w_idx        = r_lfsr[5:0];
  assign w_hit_safe   = (w_idx == {r_sr, r_sc});
  assign w_accept     = (r_state == S_PLACE) && !r_mask[w_idx] && !w_hit_safe;
  assign w_count_inc  = r_count + 6'd1;
  assign w_take_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // LFSR free-runs in every state so the board depends on when start arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start is honoured only when no board is being built.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: w_next = (r_nb == 6'd0) ? S_DONE : S_PLACE;
      S_PLACE: if (w_accept && (w_count_inc == r_nb)) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_CLEAR;
      default: w_next = S_IDLE;
    endcase
  end

  // Request parameters are captured once so later input changes cannot disturb a build.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_nb <= 6'd0;
      r_sr <= 3'd0;
      r_sc <= 3'd0;
    end else if (w_take_start) begin
      r_nb <= num_bombs;
      r_sr <= safe_row;
      r_sc <= safe_col;
    end
  end

  // Board and placed counter: wiped in CLEAR, one accepted candidate per PLACE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mask  <= 64'd0;
      r_count <= 6'd0;
    end else if (r_state == S_CLEAR) begin
      r_mask  <= 64'd0;
      r_count <= 6'd0;
    end else if (w_accept) begin
      r_mask[w_idx] <= 1'b1;
      r_count       <= w_count_inc;
    end
  end

  assign busy = (r_state == S_CLEAR) || (r_state == S_PLACE);
  assign done = (r_state == S_DONE);

  for (genvar gr = 0; gr < 8; gr++) begin : g_row
    for (genvar gc = 0; gc < 8; gc++) begin : g_col
      assign matrizBombastic[gr][gc] = r_mask[gr*8+gc] ? 4'hF : 4'h0;
    end
  end

endmodule
